ysyx_23060180_mem_responder: RTL and testbench

- Memory-side responder for the core's single-port memory interface (mem_rd/mem_wr/mem_raddr/mem_wdata/mem_wbit_en/mem_rdata).
- Serves instruction fetches, loads and stores from an internal word-organised RAM mapped at BASE_ADDR.
- Reads have a fixed one-cycle latency. Writes commit at the request edge.
- Performs byte-lane alignment: read data is returned right-justified; store data is taken from the low bits and placed into the addressed byte lanes.

---
 rtl/ysyx_23060180_mem_pkg.sv | 44 ++++
 rtl/ysyx_23060180_mem_responder_ram.sv | 32 +++
 rtl/ysyx_23060180_mem_responder.sv | 106 ++++++++++
 tb/tb_ysyx_23060180_mem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared definitions for the memory responder: store size codes, the default
// RAM base address and the byte-lane decode helper used for stores.
package ysyx_23060180_mem_pkg;

  localparam logic [3:0]  SZ_BYTE = 4'd1;
  localparam logic [3:0]  SZ_HALF = 4'd2;
  localparam logic [3:0]  SZ_WORD = 4'd4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // Byte enables for a store plus whether the size/lane pair is legal.
  typedef struct packed {
    logic [3:0] be;
    logic       legal;
  } lane_mask_t;

  // Halves must sit on lane 0 or 2, words on lane 0; any other size code is
  // illegal. The enables are only meaningful when legal is set.
  function automatic lane_mask_t lane_mask(input logic [3:0] size, input logic [1:0] lane);
    lane_mask_t r;
    r.be    = 4'b0000;
    r.legal = 1'b0;
    case (size)
      SZ_BYTE: begin
        r.be    = 4'b0001 << lane;
        r.legal = 1'b1;
      end
      SZ_HALF: begin
        r.be    = lane[1] ? 4'b1100 : 4'b0011;
        r.legal = ~lane[0];
      end
      SZ_WORD: begin
        r.be    = 4'b1111;
        r.legal = (lane == 2'd0);
      end
      default: begin
        r.be    = 4'b0000;
        r.legal = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_23060180_mem_responder_ram.sv
// DEPTH_WORDS x 32 synchronous RAM with per-byte write enables and a
// read-first output register. Contents are never reset; only the output
// register is, so the responder sees zero read data out of reset.
module ysyx_23060180_ram_bytewe #(
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rstn_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes; lanes whose enable is low keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read-first output register: a same-edge write is not visible here.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) rdata <= 32'h0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/ysyx_23060180_mem_responder.sv
// Memory-side responder for the core's single-port memory interface.
// Decodes the byte address against the RAM window, aligns store data into
// byte lanes, right-justifies read data one cycle later, and latches the
// address of the first illegal or out-of-range access.
module ysyx_23060180_mem_responder
  import ysyx_23060180_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 16384,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rstn_in,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wbit_en,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        acc_err,
  output logic [31:0] err_addr
);

  localparam int         ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  lane_mask_t        lm;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_rd;
  logic              rd_err;
  logic              wr_err;

  logic              rvalid_q;
  logic [1:0]        lane_q;
  logic              oor_q;

  // Address decode, store lane selection and error detection for this edge.
  always_comb begin
    off      = mem_raddr - BASE_ADDR;
    in_range = (mem_raddr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    widx     = off[ADDR_W+1:2];
    lane     = off[1:0];
    lm       = lane_mask(mem_wbit_en, lane);
    ram_we   = (mem_wr && in_range && lm.legal) ? lm.be : 4'b0000;
    ram_rd   = mem_rd && in_range;
    rd_err   = mem_rd && !in_range;
    wr_err   = mem_wr && (!in_range || !lm.legal);
    // Replicate the right-justified store data so every enabled lane sees it.
    case (mem_wbit_en)
      SZ_BYTE: ram_wdata = {4{mem_wdata[7:0]}};
      SZ_HALF: ram_wdata = {2{mem_wdata[15:0]}};
      default: ram_wdata = mem_wdata;
    endcase
  end

  ysyx_23060180_ram_bytewe #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rstn_in (rstn_in),
    .rd_en   (ram_rd),
    .addr    (widx),
    .we      (ram_we),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  // Per-read bookkeeping: valid pulse, lane for alignment, out-of-range mask.
  // Lane and mask only move on a read so mem_rdata holds between reads.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      rvalid_q <= 1'b0;
      lane_q   <= 2'd0;
      oor_q    <= 1'b0;
    end else begin
      rvalid_q <= mem_rd;
      if (mem_rd) begin
        lane_q <= lane;
        oor_q  <= !in_range;
      end
    end
  end

  // Sticky error flag; only the first offending address is kept.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      acc_err  <= 1'b0;
      err_addr <= 32'h0;
    end else if ((rd_err || wr_err) && !acc_err) begin
      acc_err  <= 1'b1;
      err_addr <= mem_raddr;
    end
  end

  assign mem_rdata  = oor_q ? 32'h0 : (ram_rdata >> {lane_q, 3'b000});
  assign mem_rvalid = rvalid_q;

endmodule

// File: tb/tb_ysyx_23060180_mem_responder.sv
// Bench for the memory responder: directed scenarios followed by random
// traffic, all checked against a byte-array reference model. Read results
// are queued at issue time and compared by a separate monitor.
module tb_ysyx_23060180_mem_responder;
  import ysyx_23060180_mem_pkg::*;

  localparam int          DEPTH  = 256;
  localparam int          NBYTES = 4 * DEPTH;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk;
  logic        rstn_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_raddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wbit_en;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        acc_err;
  logic [31:0] err_addr;

  ysyx_23060180_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .INIT_FILE   ("")
  ) dut (
    .clk         (clk),
    .rstn_in     (rstn_in),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_raddr   (mem_raddr),
    .mem_wdata   (mem_wdata),
    .mem_wbit_en (mem_wbit_en),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .acc_err     (acc_err),
    .err_addr    (err_addr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state and reference model
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_b [NBYTES];
  logic        exp_acc = 1'b0;
  logic [31:0] exp_eaddr = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < NBYTES);
  endfunction

  // Bytes from the addressed one up to the top of its word, zero above.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    int unsigned o, w, ln;
    v = 32'h0;
    if (!in_rng(a)) return v;
    o  = a - BASE;
    w  = o - (o % 4);
    ln = o % 4;
    for (int k = 0; k < 4; k++)
      if (ln + k < 4) v = v | (32'(ref_b[w + ln + k]) << (8 * k));
    return v;
  endfunction

  function automatic bit model_write_ok(input logic [31:0] a, input logic [3:0] sz);
    int unsigned o;
    if (!in_rng(a)) return 1'b0;
    o = a - BASE;
    return (sz == 4'd1) || (sz == 4'd2 && o % 2 == 0) || (sz == 4'd4 && o % 4 == 0);
  endfunction

  task automatic note_err(input logic [31:0] a);
    if (!exp_acc) begin
      exp_acc   = 1'b1;
      exp_eaddr = a;
    end
  endtask

  task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] sz);
    int unsigned o;
    if (rd && !in_rng(a)) note_err(a);
    if (wr) begin
      if (model_write_ok(a, sz)) begin
        o = a - BASE;
        for (int k = 0; k < int'(sz); k++) ref_b[o + k] = wd[8*k +: 8];
      end else begin
        note_err(a);
      end
    end
  endtask

  // Driver: one request cycle; read expectation is taken before the write.
  task automatic step(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] sz);
    mem_rd      = rd;
    mem_wr      = wr;
    mem_raddr   = a;
    mem_wdata   = wd;
    mem_wbit_en = sz;
    if (rd) exp_q.push_back(model_read(a));
    model_access(rd, wr, a, wd, sz);
    @(posedge clk);
    #1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    check("acc_err", {31'h0, acc_err}, {31'h0, exp_acc});
    check("err_addr", err_addr, exp_eaddr);
  endtask

  // Driver: read whose result is a fixed known value.
  task automatic rd_const(input logic [31:0] a, input logic [31:0] want);
    mem_rd    = 1'b1;
    mem_wr    = 1'b0;
    mem_raddr = a;
    exp_q.push_back(want);
    model_access(1'b1, 1'b0, a, 32'h0, 4'd0);
    @(posedge clk);
    #1;
    mem_rd = 1'b0;
    check("acc_err", {31'h0, acc_err}, {31'h0, exp_acc});
    check("err_addr", err_addr, exp_eaddr);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rstn_in && mem_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid=1 with data %08h, expected no response at %0t",
                 mem_rdata, $time);
      end else begin
        check("rdata", mem_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [3:0]  sz;
    int          r;

    rstn_in     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_raddr   = 32'h0;
    mem_wdata   = 32'h0;
    mem_wbit_en = 4'd0;
    #2;
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_rvalid", {31'h0, mem_rvalid}, 32'h0);
    check("reset_acc_err", {31'h0, acc_err}, 32'h0);
    check("reset_err_addr", err_addr, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn_in = 1'b1;
    @(posedge clk);
    #1;

    // Fill every word so the model and RAM agree everywhere.
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0) v = 32'hDEAD_BEEF;
      else if (i == 1 || i == 4) v = 32'h0;
      else v = $urandom;
      step(1'b0, 1'b1, BASE + 32'(4 * i), v, SZ_WORD);
    end

    // Single read: one-cycle pulse, data held afterwards.
    rd_const(BASE, 32'hDEAD_BEEF);
    check("rvalid_pulse_high", {31'h0, mem_rvalid}, 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    check("rvalid_pulse_low", {31'h0, mem_rvalid}, 32'h0);
    check("rdata_hold", mem_rdata, 32'hDEAD_BEEF);

    // Right-justified sub-word reads.
    rd_const(BASE + 32'd3, 32'h0000_00DE);
    rd_const(BASE + 32'd2, 32'h0000_DEAD);

    // Byte then half store into word 1.
    step(1'b0, 1'b1, BASE + 32'd5, 32'h1234_56AA, SZ_BYTE);
    rd_const(BASE + 32'd4, 32'h0000_AA00);
    step(1'b0, 1'b1, BASE + 32'd6, 32'h0000_BEEF, SZ_HALF);
    rd_const(BASE + 32'd4, 32'hBEEF_AA00);

    // Misaligned word store, then out-of-range read.
    step(1'b0, 1'b1, BASE + 32'd2, 32'h1111_1111, SZ_WORD);
    check("first_err_flag", {31'h0, acc_err}, 32'h1);
    check("first_err_addr", err_addr, 32'h8000_0002);
    rd_const(BASE, 32'hDEAD_BEEF);
    rd_const(32'h7FFF_FFFC, 32'h0);
    check("err_addr_sticky", err_addr, 32'h8000_0002);

    // Same-edge read and write: read-first, write visible next.
    step(1'b1, 1'b1, BASE + 32'h10, 32'hCAFE_F00D, SZ_WORD);
    rd_const(BASE + 32'h10, 32'hCAFE_F00D);

    // Back-to-back reads, then reset with one read in flight.
    rd_const(BASE, 32'hDEAD_BEEF);
    rd_const(BASE + 32'd4, 32'hBEEF_AA00);
    step(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'd0);
    mem_rd    = 1'b1;
    mem_raddr = BASE + 32'hC;
    exp_q.push_back(model_read(BASE + 32'hC));
    @(posedge clk);
    #1;
    mem_rd = 1'b0;
    #2;
    rstn_in = 1'b0;
    #1;
    check("midreset_rvalid", {31'h0, mem_rvalid}, 32'h0);
    check("midreset_rdata", mem_rdata, 32'h0);
    check("midreset_acc_err", {31'h0, acc_err}, 32'h0);
    check("midreset_err_addr", err_addr, 32'h0);
    exp_q.delete();
    exp_acc   = 1'b0;
    exp_eaddr = 32'h0;
    repeat (2) @(negedge clk);
    rstn_in = 1'b1;
    @(posedge clk);
    #1;
    rd_const(BASE, 32'hDEAD_BEEF);
    rd_const(BASE + 32'd4, 32'hBEEF_AA00);
    rd_const(BASE + 32'h10, 32'hCAFE_F00D);
    step(1'b1, 1'b0, BASE + 32'hC, 32'h0, 4'd0);

    // Random traffic including illegal sizes and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = BASE - 32'(4 * $urandom_range(1, 8));
      else if (r == 1) a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 64));
      else a = BASE + 32'($urandom_range(0, NBYTES - 1));
      r = $urandom_range(0, 7);
      if (r < 2) sz = SZ_BYTE;
      else if (r < 4) sz = SZ_HALF;
      else if (r < 6) sz = SZ_WORD;
      else sz = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, sz);
    end

    // Drain outstanding reads.
    repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    check("drain_outstanding", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
